// File: rtl/exec_stage_md_if.sv
// Execute-stage bundle: decoded instruction fields, operand/forwarding
// sources, and the results and status the stage hands back.
interface exec_stage_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [3:0]      alu_op;
  logic [3:0]      md_op;
  logic            alu_src;
  logic [1:0]      reg_dst;
  logic [4:0]      rs_num;
  logic [4:0]      rt_num;
  logic [4:0]      rd_num;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] alu_res_m;
  logic [XLEN-1:0] data_w;
  logic [XLEN-1:0] link_pc_m;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            flush;

  logic [XLEN-1:0] result;
  logic [XLEN-1:0] rt_value;
  logic [4:0]      wr_reg;
  logic            stall;
  logic            md_busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output in_valid, alu_op, md_op, alu_src, reg_dst, rs_num, rt_num, rd_num,
           rs_data, rt_data, ext, alu_res_m, data_w, link_pc_m, fwd_a, fwd_b, flush,
    input  result, rt_value, wr_reg, stall, md_busy, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, md_op, alu_src, reg_dst, rs_num, rt_num, rd_num,
           rs_data, rt_data, ext, alu_res_m, data_w, link_pc_m, fwd_a, fwd_b, flush,
    output result, rt_value, wr_reg, stall, md_busy, hi, lo
  );
endinterface

// File: rtl/exec_stage_md.sv
// Execute stage: forwarding muxes, ALU, and an iterative-latency
// multiply/divide unit owning the HI/LO registers.
module exec_stage_md #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 12
) (
  input logic            clk,
  input logic            rst_n,
  exec_stage_md_if.slave bus
);

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t       state_q, state_d;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] op_a_q, op_b_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q;

  logic [XLEN-1:0] src_a, src_b, rt_val, alu_out;
  logic            busy, live, is_md_any, is_md_start, accept, mt_hi, mt_lo, done;

  logic [2*XLEN-1:0] prod_s, prod_u;
  logic [XLEN-1:0]   abs_a, abs_b, uq, ur, sq, sr, dq, dr;
  logic              a_neg, b_neg;

  // Operand A: register 0 always reads zero, otherwise take the forwarded source.
  always_comb begin
    src_a = '0;
    if (bus.rs_num != 5'd0) begin
      case (bus.fwd_a)
        2'd0:    src_a = bus.rs_data;
        2'd1:    src_a = bus.alu_res_m;
        2'd2:    src_a = bus.data_w;
        default: src_a = bus.link_pc_m;
      endcase
    end
  end

  // Forwarded rt value, shared by SrcB, store data and the md operand.
  always_comb begin
    rt_val = '0;
    if (bus.rt_num != 5'd0) begin
      case (bus.fwd_b)
        2'd0:    rt_val = bus.rt_data;
        2'd1:    rt_val = bus.alu_res_m;
        2'd2:    rt_val = bus.data_w;
        default: rt_val = bus.link_pc_m;
      endcase
    end
  end

  assign src_b = bus.alu_src ? bus.ext : rt_val;

  // ALU: modulo arithmetic, no overflow trap; unknown ops produce zero.
  always_comb begin
    alu_out = '0;
    case (bus.alu_op)
      4'd0: alu_out = src_a + src_b;
      4'd1: alu_out = src_a | src_b;
      4'd2: alu_out = bus.ext << 16;
      4'd3: alu_out = src_a - src_b;
      4'd4: alu_out = src_a & src_b;
      4'd5: alu_out = src_a ^ src_b;
      4'd6: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd7: alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_out = '0;
    endcase
  end

  assign busy        = (state_q == MD_BUSY);
  assign live        = bus.in_valid & ~bus.flush;
  assign is_md_any   = (bus.md_op != 4'd0) && (bus.md_op <= MD_MTLO);
  assign is_md_start = (bus.md_op >= MD_MULT) && (bus.md_op <= MD_DIVU);
  assign accept      = live & ~busy & is_md_start;
  assign mt_hi       = live & ~busy & (bus.md_op == MD_MTHI);
  assign mt_lo       = live & ~busy & (bus.md_op == MD_MTLO);
  assign done        = busy & (cnt_q == 5'd1);

  // Full-width products; the low 2*XLEN bits of the sign-extended product are the signed product.
  assign prod_s = {{XLEN{op_a_q[XLEN-1]}}, op_a_q} * {{XLEN{op_b_q[XLEN-1]}}, op_b_q};
  assign prod_u = {{XLEN{1'b0}}, op_a_q} * {{XLEN{1'b0}}, op_b_q};

  // Signed divide via magnitudes; the most-negative / -1 case wraps back to itself with remainder 0.
  always_comb begin
    a_neg = op_a_q[XLEN-1];
    b_neg = op_b_q[XLEN-1];
    abs_a = a_neg ? (~op_a_q + 1'b1) : op_a_q;
    abs_b = b_neg ? (~op_b_q + 1'b1) : op_b_q;
    uq    = '0;
    ur    = '0;
    if (abs_b != '0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    sq = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    sr = a_neg ? (~ur + 1'b1) : ur;
    dq = '0;
    dr = '0;
    if (op_b_q != '0) begin
      dq = op_b_q;
      dq = op_a_q / dq;
      dr = op_a_q % op_b_q;
    end
  end

  // Busy-state transitions: start on acceptance, return idle on the final countdown cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_BUSY;
      MD_BUSY: if (done)   state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Busy-state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Countdown and latched operands for the operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 5'd0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_q   <= 4'd0;
    end else if (accept) begin
      cnt_q  <= (bus.md_op == MD_MULT || bus.md_op == MD_MULTU) ? 5'(MUL_LAT) : 5'(DIV_LAT);
      op_a_q <= src_a;
      op_b_q <= rt_val;
      op_q   <= bus.md_op;
    end else if (cnt_q != 5'd0) begin
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  // HI/LO: written by a completing md op, or directly by an unstalled MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      case (op_q)
        MD_MULT:  {hi_q, lo_q} <= prod_s;
        MD_MULTU: {hi_q, lo_q} <= prod_u;
        MD_DIV: begin
          if (op_b_q == '0) begin
            lo_q <= '1;
            hi_q <= op_a_q;
          end else begin
            lo_q <= sq;
            hi_q <= sr;
          end
        end
        MD_DIVU: begin
          if (op_b_q == '0) begin
            lo_q <= '1;
            hi_q <= op_a_q;
          end else begin
            lo_q <= dq;
            hi_q <= dr;
          end
        end
        default: begin
          hi_q <= hi_q;
          lo_q <= lo_q;
        end
      endcase
    end else if (mt_hi) begin
      hi_q <= src_a;
    end else if (mt_lo) begin
      lo_q <= src_a;
    end
  end

  // Result selection and destination register decode.
  always_comb begin
    bus.result = alu_out;
    if (bus.md_op == MD_MFHI)      bus.result = hi_q;
    else if (bus.md_op == MD_MFLO) bus.result = lo_q;
    bus.wr_reg = 5'd0;
    case (bus.reg_dst)
      2'd0:    bus.wr_reg = bus.rt_num;
      2'd1:    bus.wr_reg = bus.rd_num;
      2'd2:    bus.wr_reg = 5'd31;
      default: bus.wr_reg = 5'd0;
    endcase
  end

  assign bus.rt_value = rt_val;
  assign bus.stall    = live & busy & is_md_any;
  assign bus.md_busy  = busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width for operands, results, HI and LO.
REQ-002 Parameter MUL_LAT, default 5, SHALL set multiply latency in cycles (range 1..31).
REQ-003 Parameter DIV_LAT, default 12, SHALL set divide latency in cycles (range 1..31).
REQ-004 clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  the E-stage instruction is valid; when 0, the stage is a bubble.
REQ-007 alu_op  in  4  0 ADD, 1 OR, 2 LUI, 3 SUB, 4 AND, 5 XOR, 6 SLT, 7 SLTU; others yield 0.
REQ-008 md_op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
REQ-009 alu_src  in  1  0 selects the forwarded rt value as SrcB; 1 selects ext.
REQ-010 reg_dst  in  2  0 selects rt, 1 selects rd, 2 selects register 31.
REQ-011 rs_num, rt_num, rd_num  in  5 each  register numbers.
REQ-012 rs_data, rt_data, ext, alu_res_m, data_w, link_pc_m  in  XLEN each  register-file, immediate and forwarding sources.
REQ-013 fwd_a, fwd_b  in  2 each  forwarding select: 0 register file, 1 alu_res_m, 2 data_w, 3 link_pc_m.
REQ-014 flush  in  1  kills the current E instruction.
REQ-015 result  out  XLEN  ALU result, or HI/LO for MFHI/MFLO.
REQ-016 rt_value  out  XLEN  forwarded rt value, used for store data.
REQ-017 wr_reg  out  5  destination register number.
REQ-018 stall  out  1  freeze request to F/D/E; the M stage receives a bubble.
REQ-019 md_busy  out  1  a multiply or divide is in flight.
REQ-020 hi, lo  out  XLEN each  architectural HI and LO registers.

Function
REQ-021 SrcA SHALL be 0 when rs_num==0; otherwise it SHALL be the fwd_a-selected source. rt_value SHALL use the same rule with rt_num and fwd_b.
REQ-022 ALU arithmetic SHALL be modulo 2^XLEN with no overflow trap.
- LUI = ext shifted left by 16.
- SLT is signed and SLTU is unsigned; both return 1 or 0 zero-extended.
REQ-023 result, wr_reg and rt_value SHALL be combinational from the current inputs and state.
REQ-024 A MULT/MULTU/DIV/DIVU is accepted when in_valid=1, flush=0 and md_busy=0.
- Acceptance latches the operands, loads the counter with MUL_LAT or DIV_LAT, and sets md_busy on the next edge.
REQ-025 The counter SHALL decrement each cycle.
- In the cycle it reaches 0, HI/LO SHALL be written and md_busy SHALL clear.
- For MUL_LAT=5, the op accepted at edge N writes HI/LO at edge N+5.
REQ-026 Multiply: {HI,LO} = the 2*XLEN-bit product, signed for MULT and unsigned for MULTU.
REQ-027 Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-028 Divide by zero SHALL give LO = all ones and HI = dividend.
REQ-029 Signed divide of the most negative value by -1 SHALL give LO = the most negative value and HI = 0.
REQ-030 stall SHALL be 1 when in_valid=1, flush=0, md_busy=1 and md_op is 1..8. stall SHALL be 0 otherwise.
REQ-031 MTHI/MTLO SHALL write SrcA into HI or LO at the edge when executed unstalled.
REQ-032 MFHI/MFLO SHALL drive result from the committed HI/LO; since they stall while busy, they never read a stale value.
REQ-033 The stalled instruction SHALL be accepted in the cycle md_busy falls; there is no extra bubble.
REQ-034 flush=1 SHALL suppress acceptance and HI/LO writes for the current instruction only. An op already in flight SHALL complete.
REQ-035 With in_valid=0, HI/LO and the md state SHALL be unaffected except for in-flight progress.

Reset
REQ-036 At a clock edge with rst_n=0, all of the following SHALL clear, including mid-operation, and the in-flight op SHALL be discarded:
- HI = 0 and LO = 0.
- md_busy = 0 and the counter = 0.
- stall = 0.
REQ-037 The first edge with rst_n=1 SHALL accept a new op normally.

Verification
REQ-038 ADD with fwd_a=1, alu_res_m=7, rs_data=2, ext=5, alu_src=1 -> result=12. The same with rs_num=0 -> result=5.
REQ-039 MULT 0xFFFFFFFE x 3, then MFHI at the next cycle -> stall high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-040 DIV -7 by 2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU 5 by 0 -> LO=0xFFFFFFFF and HI=5.
REQ-041 DIV 0x80000000 by -1 -> LO=0x80000000 and HI=0.
REQ-042 rst_n low 3 cycles into a DIV -> md_busy=0, HI=LO=0, and a following MULTU 2 x 3 gives LO=6.
REQ-043 flush=1 with MTLO, then a MULT while busy with flush=1 -> LO unchanged, stall=0, and the in-flight op still completes.
